// File: rtl/video_sync_gen.sv
// Video raster timing generator: pentagon, classic and profi rasters.
// The counters advance on ce; sync/blank/pix_start are registered decodes that
// lag the counters by one ce-qualified cycle. The raster is switched only at
// the frame boundary, so a frame always completes with the geometry it began with.
module video_sync_gen #(
    parameter int SINGLE_CLOCK = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        ds80,
    input  logic [1:0]  screen_mode,
    output logic [11:0] hcnt,
    output logic [11:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        pix_start,
    output logic [1:0]  mode
);

    localparam logic [1:0] MODE_PENT    = 2'b00;
    localparam logic [1:0] MODE_CLASSIC = 2'b01;
    localparam logic [1:0] MODE_PROFI   = 2'b10;

    // Profi vertical total depends on the clocking scheme of the host system.
    localparam logic [11:0] PROFI_VTOTAL = (SINGLE_CLOCK != 0) ? 12'd640 : 12'd624;

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic        pix_start_q, pix_start_d;

    logic [11:0] h_total, h_active, hs_start, hs_end;
    logic [11:0] v_total, v_active, vs_start, vs_end;
    logic [1:0]  req_mode;
    logic        h_last, v_last, v_over;

    // Raster geometry of the mode currently in force.
    always_comb begin
        h_total  = 12'd896;
        h_active = 12'd768;
        hs_start = 12'd800;
        hs_end   = 12'd863;
        v_total  = 12'd640;
        v_active = 12'd608;
        vs_start = 12'd616;
        vs_end   = 12'd619;
        case (mode_q)
            MODE_CLASSIC: begin
                v_total  = 12'd624;
                v_active = 12'd576;
                vs_start = 12'd584;
                vs_end   = 12'd587;
            end
            MODE_PROFI: begin
                h_total  = 12'd768;
                h_active = 12'd608;
                hs_start = 12'd640;
                hs_end   = 12'd703;
                v_total  = PROFI_VTOTAL;
                v_active = 12'd480;
                vs_start = 12'd560;
                vs_end   = 12'd563;
            end
            default: ;
        endcase
    end

    // Decode the raster request: profi overrides the screen_mode selection.
    always_comb begin
        if (ds80)
            req_mode = MODE_PROFI;
        else if (screen_mode == 2'b01)
            req_mode = MODE_CLASSIC;
        else
            req_mode = MODE_PENT;
    end

    // Counter advance, frame-boundary mode latch and registered decodes.
    // The >= compares double as the recovery path for out-of-range counters.
    always_comb begin
        h_last      = (hcnt_q >= (h_total - 12'd1));
        v_last      = (vcnt_q >= (v_total - 12'd1));
        v_over      = (vcnt_q >= v_total);
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        mode_d      = mode_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        blank_d     = blank_q;
        pix_start_d = 1'b0;
        if (ce) begin
            if (h_last) begin
                hcnt_d = 12'd0;
                vcnt_d = v_last ? 12'd0 : (vcnt_q + 12'd1);
            end else begin
                hcnt_d = hcnt_q + 12'd1;
                vcnt_d = v_over ? 12'd0 : vcnt_q;
            end
            if (h_last && v_last)
                mode_d = req_mode;
            hsync_d     = (hcnt_q >= hs_start) && (hcnt_q <= hs_end);
            vsync_d     = (vcnt_q >= vs_start) && (vcnt_q <= vs_end);
            blank_d     = (hcnt_q >= h_active) || (vcnt_q >= v_active);
            pix_start_d = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
        end
    end

    // State registers; reset returns to the pentagon frame origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= 12'd0;
            vcnt_q      <= 12'd0;
            mode_q      <= MODE_PENT;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            blank_q     <= 1'b0;
            pix_start_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            mode_q      <= mode_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            pix_start_q <= pix_start_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign mode      = mode_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign pix_start = pix_start_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen. The reference model tracks the raster
// position as a linear pixel index modulo the frame size and derives all
// outputs from the raster tables. Long frames are shortened by forcing the
// counters to chosen positions while ce is low.
module tb_video_sync_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        ds80 = 1'b0;
    logic [1:0]  screen_mode = 2'b00;
    logic [11:0] hcnt, vcnt;
    logic        hsync, vsync, blank, pix_start;
    logic [1:0]  mode;

    int checks = 0;
    int failures = 0;
    string phase = "reset";

    logic [29:0] exp_q[$];
    logic [11:0] jh, jv;

    // model state
    int pos = 0;
    int m = 0;
    bit hs_e = 0, vs_e = 0, bl_e = 0, px_e = 0;

    typedef struct {
        int ht, vt, ha, va, hs0, hs1, vs0, vs1;
    } raster_t;

    video_sync_gen #(.SINGLE_CLOCK(0)) dut (
        .clk(clk), .reset(reset), .ce(ce), .ds80(ds80), .screen_mode(screen_mode),
        .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .vsync(vsync), .blank(blank),
        .pix_start(pix_start), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic raster_t raster(int md);
        raster_t r;
        if (md == 1)
            r = '{896, 624, 768, 576, 800, 863, 584, 587};
        else if (md == 2)
            r = '{768, 624, 608, 480, 640, 703, 560, 563};
        else
            r = '{896, 640, 768, 608, 800, 863, 616, 619};
        return r;
    endfunction

    // Advance the model over one clock with the given inputs and queue the
    // outputs the DUT must show after that clock edge.
    task automatic model_step(bit r, bit c, bit d80, logic [1:0] sm);
        raster_t rs;
        int h, v;
        logic [29:0] e;
        if (r) begin
            pos = 0; m = 0;
            hs_e = 0; vs_e = 0; bl_e = 0; px_e = 0;
        end else if (c) begin
            rs = raster(m);
            h = pos % rs.ht;
            v = pos / rs.ht;
            hs_e = (h >= rs.hs0) && (h <= rs.hs1);
            vs_e = (v >= rs.vs0) && (v <= rs.vs1);
            bl_e = (h >= rs.ha) || (v >= rs.va);
            px_e = (pos == 0);
            if (pos == rs.ht * rs.vt - 1) begin
                m = d80 ? 2 : ((sm == 2'b01) ? 1 : 0);
                pos = 0;
            end else begin
                pos = pos + 1;
            end
        end else begin
            px_e = 0;
        end
        rs = raster(m);
        h = pos % rs.ht;
        v = pos / rs.ht;
        e = {12'(h), 12'(v), 2'(m), hs_e, vs_e, bl_e, px_e};
        exp_q.push_back(e);
    endtask

    task automatic cyc(bit r, bit c, bit d80, logic [1:0] sm);
        @(negedge clk);
        reset = r; ce = c; ds80 = d80; screen_mode = sm;
        model_step(r, c, d80, sm);
    endtask

    task automatic run_rand(int n, int ce_pct);
        for (int i = 0; i < n; i++)
            cyc(0, $urandom_range(0, 99) < ce_pct, 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)));
    endtask

    // Move the DUT counters (and the model) to a chosen position while ce is low.
    task automatic jump(int h, int v);
        @(negedge clk);
        ce = 0;
        jh = 12'(h);
        jv = 12'(v);
        force dut.hcnt_q = jh;
        force dut.vcnt_q = jv;
        @(negedge clk);
        release dut.hcnt_q;
        release dut.vcnt_q;
        pos = v * raster(m).ht + h;
    endtask

    // Scoreboard monitor: compare whatever expectation is pending after each edge.
    initial begin
        logic [29:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hcnt, vcnt, mode, hsync, vsync, blank, pix_start};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s t=%0t: got h=%0d v=%0d mode=%0d hs=%b vs=%b bl=%b ps=%b required h=%0d v=%0d mode=%0d hs=%b vs=%b bl=%b ps=%b",
                             phase, $time, a[29:18], a[17:6], a[5:4], a[3], a[2], a[1], a[0],
                             e[29:18], e[17:6], e[5:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit d80c;
        logic [1:0] smc;
        raster_t rs;
        int tm;

        phase = "reset";
        for (int i = 0; i < 4; i++)
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

        phase = "first_ce";
        cyc(0, 1, 1, 2'b01);
        phase = "pent_rand";
        run_rand(2500, 75);

        for (int k = 0; k < 9; k++) begin
            tm = k % 3;
            d80c = (tm == 2);
            smc = (tm == 1) ? 2'b01 : ((tm == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 3)));
            phase = "frame_end";
            rs = raster(m);
            jump(rs.ht - 4, rs.vt - 1);
            for (int i = 0; i < 30; i++)
                cyc(0, $urandom_range(0, 3) != 0, d80c, smc);
            phase = "vactive_edge";
            rs = raster(m);
            jump(rs.ht - 3, rs.va - 1);
            run_rand(900, 80);
            phase = "vsync_start";
            jump(rs.ht - 3, rs.vs0 - 1);
            run_rand(900, 80);
            phase = "vsync_end";
            jump(rs.ht - 3, rs.vs1);
            run_rand(900, 80);
            phase = "hsync_line";
            jump(rs.hs0 - 3, $urandom_range(0, rs.vt - 1));
            run_rand(200, 80);
        end

        phase = "ce_toggle";
        rs = raster(m);
        jump(rs.ht - 6, rs.vt - 1);
        for (int i = 0; i < 600; i++)
            cyc(0, (i % 2) == 0, 1'b1, 2'b01);

        phase = "reset_mid";
        jump(500, 300);
        cyc(0, 1, 1, 2'b01);
        cyc(0, 1, 1, 2'b01);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 2'b01);
        phase = "after_reset";
        cyc(0, 1, 1, 2'b01);
        for (int i = 0; i < 50; i++)
            cyc(0, 1, 1, 2'b01);

        @(posedge clk);
        #2;
        checks++;
        if (hcnt !== 12'd51) begin
            failures++;
            $display("FAIL after_reset: hcnt=%0d required 51", hcnt);
        end
        checks++;
        if (vcnt !== 12'd0) begin
            failures++;
            $display("FAIL after_reset: vcnt=%0d required 0", vcnt);
        end
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL after_reset: mode=%0d required 0", mode);
        end

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
